// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the RPN calculator CPU.
// Owns pc and ir, drives the ROM address, register write strobe and ATC handshake.
module cpu_sequencer #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_run,
    output logic [PC_W-1:0]    o_rom_addr,
    input  logic [INSTR_W-1:0] i_rom_data,
    output logic [2:0]         o_command_group,
    output logic [2:0]         o_command,
    output logic [INSTR_W-7:0] o_immediate,
    input  logic               i_branch_select,
    input  logic               i_write_enable,
    input  logic               i_is_atc,
    input  logic               i_branch_taken,
    output logic               o_reg_we,
    output logic               o_atc_req,
    input  logic               i_atc_ack,
    output logic [PC_W-1:0]    o_pc,
    output logic               o_busy
);

    localparam int unsigned IMM_W = INSTR_W - 6;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StExec,
        StWb,
        StAtc,
        StNext
    } state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_d;
    logic [PC_W-1:0]    w_pc_inc;
    logic [PC_W-1:0]    w_target;
    logic [INSTR_W-1:0] r_ir;
    logic [PC_W-1:0]    r_rom_addr;
    logic               r_reg_we;
    logic               r_atc_req;
    logic               r_busy;

    assign w_pc_inc = r_pc + PC_W'(1);

    // Branch target: low PC_W bits of the immediate, zero-extended if narrower.
    if (IMM_W >= PC_W) begin : g_trunc
        assign w_target = r_ir[PC_W-1:0];
    end else begin : g_zext
        assign w_target = {{(PC_W - IMM_W){1'b0}}, r_ir[IMM_W-1:0]};
    end

    always_comb begin
        w_state_d = r_state;
        w_pc_d    = r_pc;
        case (r_state)
            StIdle: begin
                if (i_run) begin
                    w_state_d = StFetch;
                end
            end
            StFetch: w_state_d = StLoad;
            StLoad:  w_state_d = StExec;
            StExec: begin
                if (i_is_atc) begin
                    w_state_d = StAtc;
                end else if (i_branch_select) begin
                    w_pc_d    = i_branch_taken ? w_target : w_pc_inc;
                    w_state_d = StNext;
                end else if (i_write_enable) begin
                    w_state_d = StWb;
                end else begin
                    w_pc_d    = w_pc_inc;
                    w_state_d = StNext;
                end
            end
            StWb: begin
                w_pc_d    = w_pc_inc;
                w_state_d = StNext;
            end
            StAtc: begin
                if (i_atc_ack) begin
                    w_pc_d    = w_pc_inc;
                    w_state_d = StNext;
                end
            end
            StNext:  w_state_d = i_run ? StFetch : StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_pc       <= '0;
            r_ir       <= '0;
            r_rom_addr <= '0;
            r_reg_we   <= 1'b0;
            r_atc_req  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_pc    <= w_pc_d;
            if (r_state == StLoad) begin
                r_ir <= i_rom_data;
            end
            // Follows the next pc so a registered ROM has its word ready by LOAD.
            r_rom_addr <= w_pc_d;
            r_reg_we   <= (w_state_d == StWb);
            r_atc_req  <= (w_state_d == StAtc);
            r_busy     <= (w_state_d != StIdle);
        end
    end

    assign o_rom_addr      = r_rom_addr;
    assign o_pc            = r_pc;
    assign o_command_group = r_ir[INSTR_W-1 -: 3];
    assign o_command       = r_ir[INSTR_W-4 -: 3];
    assign o_immediate     = r_ir[IMM_W-1:0];
    assign o_reg_we        = r_reg_we;
    assign o_atc_req       = r_atc_req;
    assign o_busy          = r_busy;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed steps plus random programs,
// checked cycle by cycle against an instruction-level timing model.
module tb_cpu_sequencer;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               run = 1'b0;
    logic [PC_W-1:0]    rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic [2:0]         command_group;
    logic [2:0]         command;
    logic [INSTR_W-7:0] immediate;
    logic               branch_select;
    logic               write_enable;
    logic               is_atc;
    logic               branch_taken;
    logic               reg_we;
    logic               atc_req;
    logic               atc_ack = 1'b0;
    logic [PC_W-1:0]    pc;
    logic               busy;

    logic [INSTR_W-1:0] rom [256];
    int tests = 0;
    int fails = 0;
    int m_pc  = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_run           (run),
        .o_rom_addr      (rom_addr),
        .i_rom_data      (rom_data),
        .o_command_group (command_group),
        .o_command       (command),
        .o_immediate     (immediate),
        .i_branch_select (branch_select),
        .i_write_enable  (write_enable),
        .i_is_atc        (is_atc),
        .i_branch_taken  (branch_taken),
        .o_reg_we        (reg_we),
        .o_atc_req       (atc_req),
        .i_atc_ack       (atc_ack),
        .o_pc            (pc),
        .o_busy          (busy)
    );

    // Synchronous instruction ROM and a toy controller: groups 6 and 7 raise
    // several decisions at once so the priority order gets exercised.
    always_ff @(posedge clk) rom_data <= rom[rom_addr];
    assign is_atc        = command_group inside {3'd3, 3'd7};
    assign branch_select = command_group inside {3'd2, 3'd6, 3'd7};
    assign write_enable  = command_group inside {3'd1, 3'd5, 3'd6, 3'd7};
    assign branch_taken  = (command == 3'd0) || immediate[9];

    function automatic logic [15:0] mk(input int g, input int c, input int imm);
        return 16'((g % 8) * 8192 + (c % 8) * 1024 + (imm % 1024));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Kinds: 0 nop, 1 write, 2 branch, 3 atc.
    function automatic int classify(input logic [15:0] ins);
        int g;
        g = int'(ins) / 8192;
        if (g == 3 || g == 7) return 3;
        if (g == 2 || g == 6) return 2;
        if (g == 1 || g == 5) return 1;
        return 0;
    endfunction

    // Entered in the cycle before FETCH; returns in the NEXT cycle.
    task automatic exec_instr(input int w, input bit pre, input int drop_at);
        logic [15:0] ins;
        int kind, len, new_pc, imm, cmd;
        ins    = rom[m_pc];
        kind   = classify(ins);
        imm    = int'(ins) % 1024;
        cmd    = (int'(ins) / 1024) % 8;
        new_pc = (m_pc + 1) % 256;
        len    = 4;
        if (kind == 1) len = 5;
        if (kind == 3) len = 5 + w;
        if (kind == 2 && (cmd == 0 || imm >= 512)) new_pc = imm % 256;
        for (int k = 1; k <= len; k++) begin
            @(posedge clk);
            #1;
            if (kind == 3) atc_ack = (k == 4 + w) || (pre && k < 4);
            else atc_ack = pre;
            if (k == drop_at) run = 1'b0;
            chk("busy", 32'(busy), 32'd1);
            chk("reg_we", 32'(reg_we), 32'(kind == 1 && k == 4));
            chk("atc_req", 32'(atc_req), 32'(kind == 3 && k >= 4 && k < len));
            chk("pc", 32'(pc), 32'((k == len) ? new_pc : m_pc));
            chk("rom_addr", 32'(rom_addr), 32'((k == len) ? new_pc : m_pc));
            if (k == 3) begin
                chk("command_group", 32'(command_group), 32'(int'(ins) / 8192));
                chk("command", 32'(command), 32'(cmd));
                chk("immediate", 32'(immediate), 32'(imm));
            end
        end
        atc_ack = 1'b0;
        m_pc = new_pc;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_pc", 32'(pc), 32'(m_pc));
            chk("idle_reg_we", 32'(reg_we), 32'd0);
            chk("idle_atc_req", 32'(atc_req), 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rom[8'h00] = mk(0, 0, 0);
        rom[8'h01] = mk(0, 0, 0);
        rom[8'h02] = mk(1, 0, 5);
        rom[8'h03] = mk(2, 1, 16'h020);
        rom[8'h04] = mk(2, 0, 16'h120);
        rom[8'h20] = mk(3, 0, 0);
        rom[8'h21] = mk(3, 0, 0);
        rom[8'h22] = mk(7, 0, 16'h3FF);
        rom[8'h23] = mk(6, 0, 16'h0FF);
        rom[8'hFF] = mk(0, 0, 0);

        #1 reset = 1'b1;
        #11;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_reg_we", 32'(reg_we), 32'd0);
        chk("rst_atc_req", 32'(atc_req), 32'd0);
        chk("rst_ir", 32'({command_group, command, immediate}), 32'd0);
        @(negedge clk) reset = 1'b0;
        idle_cycles(2);
        run = 1'b1;

        exec_instr(0, 1'b0, 0);  // NOP at 0
        exec_instr(0, 1'b0, 0);  // NOP at 1
        exec_instr(0, 1'b0, 0);  // write at 2
        exec_instr(0, 1'b0, 0);  // EQ not taken -> 4
        exec_instr(0, 1'b0, 0);  // JMP with wide immediate -> 0x20
        exec_instr(5, 1'b0, 0);  // ATC, 5-cycle wait
        exec_instr(0, 1'b1, 0);  // ATC, ack pre-asserted
        exec_instr(2, 1'b0, 0);  // all decisions set: ATC wins
        exec_instr(0, 1'b1, 0);  // branch beats write -> 0xFF, stray ack ignored
        exec_instr(0, 1'b0, 0);  // NOP at 0xFF wraps to 0
        exec_instr(0, 1'b0, 0);
        exec_instr(0, 1'b0, 0);
        exec_instr(0, 1'b0, 3);  // write at 2, run dropped in EXEC
        idle_cycles(3);

        // Async reset while waiting in ATC.
        rom[m_pc] = mk(3, 2, 0);
        rom[0]    = mk(0, 0, 0);
        run = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
        end
        chk("atc_wait_req", 32'(atc_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_atc_req", 32'(atc_req), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_pc", 32'(pc), 32'd0);
        chk("async_rom_addr", 32'(rom_addr), 32'd0);
        chk("async_reg_we", 32'(reg_we), 32'd0);
        @(negedge clk) reset = 1'b0;
        m_pc = 0;
        exec_instr(0, 1'b0, 0);

        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        for (int n = 0; n < 150; n++) begin
            int drop;
            drop = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
            exec_instr(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), drop);
            if (drop != 0) begin
                idle_cycles(int'($urandom_range(1, 3)));
                run = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
